isr_sched: RTL and testbench
============================

ISR_SCHED -- requirements
Module: isr_sched

Interface
REQ-001 SHALL have parameter NREQ, default 4, meaning number of requesters (2..8).
REQ-002 SHALL have parameter TIMEOUT, default 600, meaning maximum RUN cycles before aborting a job.
REQ-003 SHALL have port clock  input  1  rising-edge clock for all state.
REQ-004 SHALL have port reset  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port req_valid  input  NREQ  per-requester job request.
REQ-006 SHALL have port req_value  input  64*NREQ  per-requester radicand; slice i is bits [64*i+63:64*i].
REQ-007 SHALL have port req_ready  output  NREQ  one-hot accept pulse.
REQ-008 SHALL have port rsp_valid  output  1  result available.
REQ-009 SHALL have port rsp_ready  input  1  consumer accepts result.
REQ-010 SHALL have port rsp_id  output  clog2(NREQ)  index of the requester that owns the result.
REQ-011 SHALL have port rsp_result  output  32  floor(sqrt(value)).
REQ-012 SHALL have port rsp_err  output  1  job timed out; rsp_result is 0.
REQ-013 SHALL have port isr_reset  output  1  active-high start/clear to the shared ISR unit.
REQ-014 SHALL have port isr_value  output  64  radicand to the ISR unit.
REQ-015 SHALL have port isr_done  input  1  ISR completion.
REQ-016 SHALL have port isr_result  input  32  ISR root.
REQ-017 SHALL have port busy  output  1  high in any state except IDLE.

Function
REQ-018 SHALL implement states IDLE, LOAD, RUN, RESP.
REQ-019 IDLE: SHALL hold isr_reset=1; if any req_valid is set, SHALL grant one requester by round-robin starting at rr_ptr.
REQ-020 In the grant cycle, SHALL pulse req_ready[g] for exactly one cycle, capture req_value slice g into isr_value, capture g into rsp_id, set rr_ptr=(g+1) mod NREQ, and go to LOAD.
REQ-021 LOAD: SHALL last exactly one cycle with isr_reset=1, then go to RUN.
REQ-022 RUN: SHALL hold isr_reset=0 and isr_value stable, and SHALL ignore isr_done in the first RUN cycle (stale-done guard).
REQ-023 RUN: on isr_done=1, SHALL register isr_result into rsp_result, set rsp_err=0, and go to RESP.
REQ-024 RUN: SHALL count cycles; when the count reaches TIMEOUT with no done, SHALL set rsp_result=0 and rsp_err=1 and go to RESP.
REQ-025 RESP: SHALL hold rsp_valid=1 with stable rsp_id/rsp_result/rsp_err until rsp_ready=1; on handshake, SHALL go to IDLE; isr_reset SHALL be 1 in RESP.
REQ-026 Latency: request accepted at cycle T -> LOAD at T+1 -> RUN from T+2 -> rsp_valid one cycle after the first qualifying isr_done.
REQ-027 SHALL accept no new request outside IDLE; req_ready SHALL be 0 in LOAD/RUN/RESP.
REQ-028 A requester dropping req_valid before grant SHALL lose no state; requests are not queued internally.
REQ-029 A requester SHALL be granted within NREQ jobs while its req_valid is held (no starvation).
REQ-030 After the RESP handshake, SHALL spend at least one cycle in IDLE before the next grant.

Reset
REQ-031 While reset=0 at a rising edge: state=IDLE, rr_ptr=0, req_ready=0, rsp_valid=0, rsp_id=0, rsp_result=0, rsp_err=0, isr_value=0, isr_reset=1, busy=0, timeout counter=0.
REQ-032 Reset mid-job (LOAD/RUN/RESP) SHALL abandon the job with no response; the next grant restarts from rr_ptr=0.

Verification
REQ-033 Single requester 0, value 0x1001, ISR model -> req_ready[0] pulse, rsp_id=0, rsp_result=0x40, rsp_err=0.
REQ-034 Requesters 0..3 simultaneously valid with values 400, 0, 0xFFFF_FFFF_FFFF_FFFF, 2 -> grant order 0,1,2,3; results 20, 0, 0xFFFF_FFFF, 1.
REQ-035 rsp_ready held low 20 cycles after rsp_valid -> outputs stable, no new grant, busy=1 throughout.
REQ-036 ISR model never asserts done, TIMEOUT=50 -> rsp_valid with rsp_err=1, rsp_result=0 exactly 50 RUN cycles after RUN entry.
REQ-037 reset=0 for one cycle during RUN -> all outputs at reset values, no rsp_valid; next request on requester 2 is granted and completes normally.
REQ-038 10 random {$random,$random} jobs across random requesters -> each result r satisfies r*r <= v < (r+1)*(r+1) (all-ones v: r=0xFFFF_FFFF), and rsp_id matches the issuing requester.

Source files
------------

// File: rtl/isr_sched.sv
// isr_sched: round-robin scheduler that time-shares one integer-square-root
// unit among NREQ requesters, with a per-job timeout and a held response.
module isr_sched #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned TIMEOUT = 600
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [64*NREQ-1:0]      req_value,
    output logic [NREQ-1:0]         req_ready,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [$clog2(NREQ)-1:0] rsp_id,
    output logic [31:0]             rsp_result,
    output logic                    rsp_err,
    output logic                    isr_reset,
    output logic [63:0]             isr_value,
    input  logic                    isr_done,
    input  logic [31:0]             isr_result,
    output logic                    busy
);
    localparam int unsigned IDW = $clog2(NREQ);
    localparam int unsigned CW  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IDW-1:0]   r_rr_ptr;
    logic [CW-1:0]    r_cnt;
    logic             r_idle_hold;
    logic [63:0]      r_isr_value;
    logic [IDW-1:0]   r_rsp_id;
    logic [31:0]      r_rsp_result;
    logic             r_rsp_err;
    logic             r_rsp_valid;
    logic             r_busy;
    logic             r_isr_reset;

    logic             w_any;
    logic [IDW-1:0]   w_gnt_idx;
    logic             w_grant;
    logic             w_done_ok;
    logic             w_timeout;
    logic [63:0]      w_vals [NREQ];

    for (genvar j = 0; j < NREQ; j++) begin : g_slice
        assign w_vals[j] = req_value[64*j +: 64];
    end

    // Round-robin search starting at r_rr_ptr
    always_comb begin : arb
        w_any     = 1'b0;
        w_gnt_idx = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!w_any && req_valid[IDW'((32'(r_rr_ptr) + i) % NREQ)]) begin
                w_any     = 1'b1;
                w_gnt_idx = IDW'((32'(r_rr_ptr) + i) % NREQ);
            end
        end
    end

    // One idle cycle after each response before granting again
    assign w_grant   = (r_state == ST_IDLE) && !r_idle_hold && w_any;
    assign req_ready = (w_grant && reset) ? (NREQ'(1) << w_gnt_idx) : '0;

    always_ff @(posedge clock) begin : state_reg
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin : fsm_next
        w_state_nxt = r_state;
        w_done_ok   = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_grant) begin
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: w_state_nxt = ST_RUN;
            ST_RUN: begin
                // A done seen in the first RUN cycle may be left over from the previous job
                w_done_ok = isr_done && (r_cnt != '0);
                w_timeout = !w_done_ok && (r_cnt == CW'(TIMEOUT - 1));
                if (w_done_ok || w_timeout) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin : datapath
        if (!reset) begin
            r_rr_ptr     <= '0;
            r_cnt        <= '0;
            r_idle_hold  <= 1'b0;
            r_isr_value  <= '0;
            r_rsp_id     <= '0;
            r_rsp_result <= '0;
            r_rsp_err    <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_busy       <= 1'b0;
            r_isr_reset  <= 1'b1;
        end else begin
            r_rsp_valid <= (w_state_nxt == ST_RESP);
            r_busy      <= (w_state_nxt != ST_IDLE);
            r_isr_reset <= (w_state_nxt != ST_RUN);
            r_idle_hold <= (r_state == ST_RESP) && rsp_ready;

            if (w_grant) begin
                r_isr_value <= w_vals[w_gnt_idx];
                r_rsp_id    <= w_gnt_idx;
                r_rr_ptr    <= (w_gnt_idx == IDW'(NREQ - 1)) ? '0 : w_gnt_idx + IDW'(1);
            end

            if (r_state == ST_RUN) begin
                r_cnt <= r_cnt + CW'(1);
            end else begin
                r_cnt <= '0;
            end

            if (w_done_ok) begin
                r_rsp_result <= isr_result;
                r_rsp_err    <= 1'b0;
            end else if (w_timeout) begin
                r_rsp_result <= '0;
                r_rsp_err    <= 1'b1;
            end
        end
    end

    assign rsp_valid  = r_rsp_valid;
    assign rsp_id     = r_rsp_id;
    assign rsp_result = r_rsp_result;
    assign rsp_err    = r_rsp_err;
    assign isr_reset  = r_isr_reset;
    assign isr_value  = r_isr_value;
    assign busy       = r_busy;

endmodule

// File: tb/tb_isr_sched.sv
// tb_isr_sched: randomized self-checking bench for isr_sched with a
// behavioural ISR unit and a cycle-level scheduling reference model.
module tb_isr_sched;
    localparam int unsigned NREQ = 4;
    localparam int unsigned TMO  = 50;

    logic                 clock = 1'b0;
    logic                 reset;
    logic [NREQ-1:0]      req_valid;
    logic [64*NREQ-1:0]   req_value;
    logic [NREQ-1:0]      req_ready;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [1:0]           rsp_id;
    logic [31:0]          rsp_result;
    logic                 rsp_err;
    logic                 isr_reset;
    logic [63:0]          isr_value;
    logic                 isr_done;
    logic [31:0]          isr_result;
    logic                 busy;

    isr_sched #(.NREQ(NREQ), .TIMEOUT(TMO)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_value(req_value), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_err(rsp_err),
        .isr_reset(isr_reset), .isr_value(isr_value),
        .isr_done(isr_done), .isr_result(isr_result), .busy(busy)
    );

    always #5 clock = ~clock;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    int          m_ptr = 0;
    int unsigned isr_lat = 3;
    bit          isr_never = 1'b0;
    bit          isr_stale = 1'b0;
    int unsigned m_cnt = 0;
    logic [1:0]  last_id;
    logic [31:0] last_result;
    logic        last_err;

    function automatic logic [31:0] isqrt(input logic [63:0] v);
        logic [31:0] r;
        logic [31:0] t;
        r = '0;
        for (int b = 31; b >= 0; b--) begin
            t = r | (32'd1 << b);
            if (64'(t) * 64'(t) <= v) r = t;
        end
        return r;
    endfunction

    function automatic int rr_pick(input logic [NREQ-1:0] v, input int p);
        int k;
        for (int i = 0; i < NREQ; i++) begin
            k = (p + i) % NREQ;
            if (v[k]) return k;
        end
        return -1;
    endfunction

    // Behavioural ISR unit: done 'isr_lat' cycles into RUN; optional stale done in cycle 0
    always @(posedge clock) begin
        if (isr_reset) m_cnt <= 0;
        else           m_cnt <= m_cnt + 1;
    end

    always_comb begin
        isr_done   = 1'b0;
        isr_result = '0;
        if (!isr_reset) begin
            if (isr_stale && m_cnt == 0) begin
                isr_done   = 1'b1;
                isr_result = 32'hDEAD_BEEF;
            end else if (!isr_never && m_cnt >= isr_lat) begin
                isr_done   = 1'b1;
                isr_result = isqrt(isr_value);
            end
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    // Runs one job from grant to handshake; returns at the drive point of the next IDLE cycle
    task automatic do_job(input int hold);
        int          n;
        int          g;
        int          exp_n;
        logic [63:0] v;
        logic [31:0] er;
        logic        exp_err;
        logic [64:0] sq0;
        logic [64:0] sq1;
        n = 0;
        @(negedge clock);
        while (req_ready == '0 && n < 20) begin
            cyc();
            @(negedge clock);
            n++;
        end
        if (req_ready == '0) begin
            check_eq("grant_wait", 64'(n), 64'(0));
            return;
        end
        g = rr_pick(req_valid, m_ptr);
        if (g < 0) begin
            check_eq("grant_spurious", 64'(req_ready), 64'(0));
            return;
        end
        check_eq("grant_onehot", 64'(req_ready), 64'(NREQ'(1) << g));
        v       = req_value[64*g +: 64];
        m_ptr   = (g + 1) % NREQ;
        exp_err = isr_never || (isr_lat >= TMO);
        exp_n   = exp_err ? int'(TMO) : int'(isr_lat) + 1;
        er      = exp_err ? 32'd0 : isqrt(v);

        cyc();
        req_valid[g] = 1'b0;
        @(negedge clock);
        check_eq("load_ready", 64'(req_ready), 64'(0));
        check_eq("load_busy", 64'(busy), 64'(1));
        check_eq("load_isr_reset", 64'(isr_reset), 64'(1));
        check_eq("load_value", isr_value, v);

        n = 0;
        while (1) begin
            cyc();
            @(negedge clock);
            if (rsp_valid || n >= 200) break;
            check_eq("run_isr_reset", 64'(isr_reset), 64'(0));
            check_eq("run_value", isr_value, v);
            check_eq("run_ready", 64'(req_ready), 64'(0));
            n++;
        end
        check_eq("run_cycles", 64'(n), 64'(exp_n));
        if (!rsp_valid) return;

        last_id     = rsp_id;
        last_result = rsp_result;
        last_err    = rsp_err;
        check_eq("rsp_id", 64'(rsp_id), 64'(g));
        check_eq("rsp_result", 64'(rsp_result), 64'(er));
        check_eq("rsp_err", 64'(rsp_err), 64'(exp_err));
        check_eq("rsp_isr_reset", 64'(isr_reset), 64'(1));
        if (!exp_err) begin
            sq0 = 65'(rsp_result) * 65'(rsp_result);
            sq1 = (65'(rsp_result) + 65'd1) * (65'(rsp_result) + 65'd1);
            check_eq("root_bound", 64'((sq0 <= 65'(v)) && (65'(v) < sq1)), 64'(1));
        end
        for (int h = 0; h < hold; h++) begin
            cyc();
            @(negedge clock);
            check_eq("hold_valid", 64'(rsp_valid), 64'(1));
            check_eq("hold_fields", {29'(0), rsp_err, rsp_id, rsp_result}, {29'(0), exp_err, 2'(g), er});
            check_eq("hold_busy", 64'(busy), 64'(1));
            check_eq("hold_ready", 64'(req_ready), 64'(0));
        end
        rsp_ready = 1'b1;
        cyc();
        rsp_ready = 1'b0;
        @(negedge clock);
        check_eq("gap_valid", 64'(rsp_valid), 64'(0));
        check_eq("gap_busy", 64'(busy), 64'(0));
        check_eq("gap_ready", 64'(req_ready), 64'(0));
        cyc();
    endtask

    initial begin
        logic [31:0] exp34 [4];
        int n;
        exp34[0] = 32'd20; exp34[1] = 32'd0; exp34[2] = 32'hFFFF_FFFF; exp34[3] = 32'd1;
        reset = 1'b0; req_valid = '0; req_value = '0; rsp_ready = 1'b0;

        // Reset, with a request pending that must not be accepted
        cyc();
        req_valid[0] = 1'b1;
        @(negedge clock);
        cyc();
        @(negedge clock);
        check_eq("rst_ready", 64'(req_ready), 64'(0));
        check_eq("rst_outputs", {rsp_valid, busy, isr_reset, rsp_err, rsp_id, rsp_result},
                 {1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 32'd0});
        check_eq("rst_isr_value", isr_value, 64'd0);
        cyc();
        reset = 1'b1;
        req_valid = '0;

        // Single requester 0, with a stale done in the first RUN cycle
        req_value[63:0] = 64'h1001; req_valid[0] = 1'b1;
        isr_lat = 5; isr_stale = 1'b1;
        do_job(0);
        check_eq("single_id", 64'(last_id), 64'(0));
        check_eq("single_result", 64'(last_result), 64'h40);
        check_eq("single_err", 64'(last_err), 64'(0));

        // Requester 3 alone moves the pointer back to 0
        isr_stale = 1'b0; isr_lat = 2;
        req_value[255:192] = 64'd81; req_valid[3] = 1'b1;
        do_job(1);
        check_eq("r3_result", 64'(last_result), 64'd9);

        // All four valid: grant order 0..3; first response held 20 cycles
        req_value = {64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd400};
        req_valid = 4'hF;
        for (int i = 0; i < 4; i++) begin
            isr_lat = $urandom_range(20, 1);
            do_job(i == 0 ? 20 : 0);
            check_eq("order_id", 64'(last_id), 64'(i));
            check_eq("order_result", 64'(last_result), 64'(exp34[i]));
        end

        // Timeout and its boundaries
        isr_never = 1'b1;
        req_value[127:64] = 64'd1000; req_valid[1] = 1'b1;
        do_job(0);
        check_eq("tmo_err", 64'(last_err), 64'(1));
        check_eq("tmo_result", 64'(last_result), 64'(0));
        isr_never = 1'b0; isr_lat = TMO;
        req_value[191:128] = 64'd49; req_valid[2] = 1'b1;
        do_job(0);
        check_eq("tmo_late_err", 64'(last_err), 64'(1));
        isr_lat = TMO - 1;
        req_value[191:128] = 64'd12345; req_valid[2] = 1'b1;
        do_job(0);
        check_eq("tmo_edge_err", 64'(last_err), 64'(0));

        // Reset pulse during RUN abandons the job
        isr_lat = 40;
        req_value[191:128] = 64'd77777; req_valid[2] = 1'b1;
        n = 0;
        @(negedge clock);
        while (req_ready == '0 && n < 20) begin cyc(); @(negedge clock); n++; end
        check_eq("mid_grant", 64'(req_ready), 64'(4'b0100));
        cyc();
        req_valid[2] = 1'b0;
        cyc(); cyc(); cyc();
        reset = 1'b0;
        cyc();
        reset = 1'b1;
        m_ptr = 0;
        @(negedge clock);
        check_eq("mid_outputs", {rsp_valid, busy, isr_reset, rsp_err, rsp_id, rsp_result},
                 {1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 32'd0});
        check_eq("mid_isr_value", isr_value, 64'd0);
        for (int i = 0; i < 5; i++) begin
            cyc();
            @(negedge clock);
            check_eq("mid_quiet", {62'(0), rsp_valid, busy}, 64'(0));
        end
        cyc();
        isr_lat = 4;
        req_value[191:128] = 64'd144; req_value[255:192] = 64'd10;
        req_valid[2] = 1'b1; req_valid[3] = 1'b1;
        do_job(0);
        check_eq("post_rst_id", 64'(last_id), 64'(2));
        check_eq("post_rst_result", 64'(last_result), 64'd12);
        do_job(0);
        check_eq("post_rst_id3", 64'(last_id), 64'(3));

        // Random jobs across random requesters
        for (int j = 0; j < 12; j++) begin
            if ($urandom_range(3, 0) == 0) req_valid[$urandom_range(NREQ - 1, 0)] = 1'b0;
            for (int k = 0; k < NREQ; k++) begin
                if (!req_valid[k] && $urandom_range(1, 0) == 1) begin
                    req_value[64*k +: 64] = {$urandom, $urandom};
                    req_valid[k] = 1'b1;
                end
            end
            if (req_valid == '0) begin
                req_value[64*(j % NREQ) +: 64] = {$urandom, $urandom};
                req_valid[j % NREQ] = 1'b1;
            end
            isr_lat   = $urandom_range(30, 1);
            isr_stale = 1'($urandom_range(1, 0));
            do_job($urandom_range(3, 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

endmodule
